// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - binary to packed BCD converter (shift-and-add-3) for the multiplier product
// Optional feature macro: LEADING_ZERO_BLANK_EN (adds the registered leading-zero blank mask port).
module product_bcd_converter #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [IN_W-1:0]    sr_q, sr_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;
  logic               trigger;

  // Rising edge of the multiplier finish flag; a level held high triggers once.
  assign trigger = start & ~start_q;

  // Add-3 correction on every scratch digit that would overflow past 9 after doubling.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath: load on trigger, shift IN_W times, then publish the result.
  always_comb begin
    state_d   = state_q;
    start_d   = start;
    sr_d      = sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (trigger) begin
          sr_d      = bin;
          scratch_d = '0;
          cnt_d     = CNT_LOAD;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, sr_d} = {adj, sr_q} << 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM, shift datapath and registered outputs; reset aborts a conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      sr_q      <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      sr_q      <= sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, lead_zero;
  logic              zero_above;

  // Digit i is blanked when it and every higher digit are zero; the units digit always shows.
  always_comb begin
    zero_above = 1'b1;
    lead_zero  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (scratch_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_above;
    end
  end

  // Blank mask updates on the same edge as bcd.
  always_comb begin
    blank_d = blank_q;
    if (state_q == DONE) begin
      blank_d = lead_zero;
    end
  end

  // Registered blank mask, cleared with the rest of the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule

// File: doc/product_bcd_converter.md
PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

Interface
REQ-001 Parameter IN_W, default 8, binary input width; matches the 8-bit product of the upstream 4x4 serial multiplier.
REQ-002 Parameter DIGITS, default 3, number of BCD output digits; legal only when 10^DIGITS > 2^IN_W - 1.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  level request, driven from the multiplier finish flag; only its rising edge triggers a conversion.
REQ-006 Port bin  input  IN_W  unsigned binary value, the multiplier product; sampled only on the trigger edge.
REQ-007 Port bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-008 Port busy  output  1  high while a conversion is in progress.
REQ-009 Port done  output  1  one-cycle pulse marking bcd updated with a new result.

Function
REQ-010 The block SHALL register start every cycle and detect a trigger when start=1 and the registered copy is 0.
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 IDLE: on trigger, load bin into the shift register, clear the BCD scratch digits, set the bit counter to IN_W, and go to SHIFT.
REQ-013 SHIFT: each cycle, add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit, and decrement the counter; after the IN_W-th shift, go to DONE.
REQ-014 DONE: copy scratch to bcd, assert done for exactly one cycle, and return to IDLE.
REQ-015 Latency: done SHALL be high in the cycle IN_W+1 clocks after the trigger edge (9 for IN_W=8); bcd SHALL change on the same edge that raises done.
REQ-016 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-017 Triggers arriving while busy=1 SHALL be ignored; they are not queued, and the edge detector keeps tracking start.
REQ-018 start held high SHALL produce exactly one conversion.
REQ-019 A trigger in the cycle after done SHALL be accepted normally, allowing back-to-back conversions.
REQ-020 bcd SHALL hold its last result until the next DONE; bin changes outside the trigger edge have no effect.
REQ-021 Every digit written to bcd SHALL be in the range 0..9.

Reset
REQ-022 While reset is asserted, the block SHALL force state IDLE, bcd=0, busy=0, done=0, counter=0, scratch=0 and registered start=0, asynchronously.
REQ-023 Reset mid-conversion SHALL abort the conversion with no done pulse and no bcd update.
REQ-024 If start is already high when reset releases, the first sampled edge SHALL count as a trigger.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL add output port blank (DIGITS bits, registered and updated with bcd), with bit i=1 when digit i and all higher digits are 0, for i >= 1.
REQ-026 Under LEADING_ZERO_BLANK_EN, blank bit 0 SHALL always be 0 so the units digit always shows; blank SHALL reset to 0.
REQ-027 When LEADING_ZERO_BLANK_EN is undefined, port blank and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Pulse start with bin=8'd0 -> done 9 cycles later, bcd=12'h000; blank=3'b110 if enabled.
REQ-029 Convert bin=8'd255, then 8'd100, then 8'd99 -> bcd=12'h255, 12'h100, 12'h099 respectively; blank for 99 is 3'b100.
REQ-030 Hold start high for 30 cycles with bin=8'd225 (15x15) -> exactly one done pulse, bcd=12'h225.
REQ-031 Trigger on 8'd42, then raise a second edge with bin=8'd7 at cycle 4 -> one done only, bcd=12'h042, busy continuous for 9 cycles.
REQ-032 Assert reset at cycle 5 of a conversion of 8'd200 -> no done pulse; bcd=0 and busy=0 immediately; a following trigger on 8'd7 -> bcd=12'h007.
REQ-033 Back-to-back: trigger 8'd12, then retrigger the cycle after done with 8'd34 -> bcd=12'h012, then 12'h034, with two done pulses 10 cycles apart.
